// File: rtl/muu_mem_arbiter_pkg.sv
// muu_mem_pkg: shared command field positions, requester ids and write FSM encoding
package muu_mem_pkg;
    localparam int CMD_ADDR_LSB = 0;
    localparam int CMD_LEN_LSB = 32;
    localparam int CMD_LEN_W = 8;
    localparam int RQ_ID_W = 1;
    localparam logic [RQ_ID_W-1:0] RQ_VALSET = 1'b0;
    localparam logic [RQ_ID_W-1:0] RQ_SCAN = 1'b1;
    typedef enum logic {WR_IDLE, WR_DATA} wr_state_t;
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/muu_mem_arbiter_if.sv
// muu_mem_arbiter_if: valid/ready stream carrying one command or data beat
interface muu_mem_arbiter_if #(
    parameter int W = 40
);
    logic [W-1:0] data;
    logic valid;
    logic ready;
    modport master (output data, valid, input ready);
    modport slave (input data, valid, output ready);
endinterface

// File: rtl/muu_mem_arbiter_rr.sv
// muu_rr_arb2: two-input round-robin grant, pointer names the preferred requester
module muu_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_id
);
    logic ptr;
    // Contended requests go to the pointer; a lone request wins outright
    always_comb begin
        gnt_id = &req ? ptr : req[1];
        gnt = (en && |req) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    end
    // Prefer the other requester after every grant
    always_ff @(posedge clk) begin
        if (rst) ptr <= 1'b0;
        else if (|gnt) ptr <= !gnt_id;
    end
endmodule

// File: rtl/muu_mem_arbiter.sv
// muu_mem_arbiter: shares one value-memory port between value-set and scan requesters (stats under MUU_MEMARB_STATS_EN)
module muu_mem_arbiter
    import muu_mem_pkg::*;
#(
    parameter int MEMORY_WIDTH = 512,
    parameter int CMD_WIDTH = 40,
    parameter int ORDER_DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    muu_mem_arbiter_if.slave  rq0_rdcmd,
    muu_mem_arbiter_if.slave  rq1_rdcmd,
    muu_mem_arbiter_if.slave  rq0_wrcmd,
    muu_mem_arbiter_if.slave  rq1_wrcmd,
    muu_mem_arbiter_if.slave  rq0_wr,
    muu_mem_arbiter_if.slave  rq1_wr,
    muu_mem_arbiter_if.master rq0_rd,
    muu_mem_arbiter_if.master rq1_rd,
    muu_mem_arbiter_if.master mem_rdcmd,
    muu_mem_arbiter_if.master mem_wrcmd,
    muu_mem_arbiter_if.master mem_wr,
    muu_mem_arbiter_if.slave  mem_rd
`ifdef MUU_MEMARB_STATS_EN
    ,
    output logic [31:0] stat_rdcmd0,
    output logic [31:0] stat_rdcmd1,
    output logic [31:0] stat_wrcmd0,
    output logic [31:0] stat_wrcmd1,
    output logic [31:0] stat_fifo_full_cycles
`endif
);
    localparam int AW = $clog2(ORDER_DEPTH);
    localparam int EW = RQ_ID_W + CMD_LEN_W;

    logic [EW-1:0] ord_mem [ORDER_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic full, empty;
    logic [1:0] rd_gnt, wr_gnt;
    logic rd_id, wr_id, rd_en, wr_en;
    logic [CMD_WIDTH-1:0] rd_cmd, wr_cmd;
    logic [CMD_LEN_W-1:0] rd_len, wr_cmd_len, head_len, rd_cnt, wr_len, wr_cnt;
    logic head_id, rd_push, rd_pop, rd_beat, wr_beat, wr_owner;
    wr_state_t wr_state, wr_state_n;

    assign full = cnt == (AW+1)'(ORDER_DEPTH);
    assign empty = cnt == '0;
    assign rd_en = !rst && !full && (!mem_rdcmd.valid || mem_rdcmd.ready);
    assign wr_en = !rst && wr_state == WR_IDLE && (!mem_wrcmd.valid || mem_wrcmd.ready);

    muu_rr_arb2 u_rd_arb (
        .clk(clk), .rst(rst), .req({rq1_rdcmd.valid, rq0_rdcmd.valid}),
        .en(rd_en), .gnt(rd_gnt), .gnt_id(rd_id)
    );
    muu_rr_arb2 u_wr_arb (
        .clk(clk), .rst(rst), .req({rq1_wrcmd.valid, rq0_wrcmd.valid}),
        .en(wr_en), .gnt(wr_gnt), .gnt_id(wr_id)
    );

    // Read command acceptance and in-order routing of returned beats to the FIFO head's owner
    always_comb begin
        rd_cmd = rd_id ? rq1_rdcmd.data : rq0_rdcmd.data;
        rd_len = rd_cmd[CMD_LEN_LSB +: CMD_LEN_W];
        rd_push = |rd_gnt && rd_len != '0;
        rq0_rdcmd.ready = rd_gnt[0];
        rq1_rdcmd.ready = rd_gnt[1];
        head_id = ord_mem[rp][EW-1];
        head_len = ord_mem[rp][CMD_LEN_W-1:0];
        mem_rd.ready = !empty && (head_id ? rq1_rd.ready : rq0_rd.ready);
        rq0_rd.valid = !empty && head_id == RQ_VALSET && mem_rd.valid;
        rq1_rd.valid = !empty && head_id == RQ_SCAN && mem_rd.valid;
        rq0_rd.data = rq0_rd.valid ? mem_rd.data : MEMORY_WIDTH'(0);
        rq1_rd.data = rq1_rd.valid ? mem_rd.data : MEMORY_WIDTH'(0);
        rd_beat = mem_rd.valid && mem_rd.ready;
        rd_pop = rd_beat && rd_cnt == head_len - 8'd1;
    end

    // Write FSM: grant a command in idle, then lock write data to its owner for L beats
    always_comb begin
        wr_state_n = wr_state;
        wr_cmd = wr_id ? rq1_wrcmd.data : rq0_wrcmd.data;
        wr_cmd_len = wr_cmd[CMD_LEN_LSB +: CMD_LEN_W];
        rq0_wrcmd.ready = wr_gnt[0];
        rq1_wrcmd.ready = wr_gnt[1];
        mem_wr.valid = wr_state == WR_DATA && (wr_owner ? rq1_wr.valid : rq0_wr.valid);
        mem_wr.data = mem_wr.valid ? (wr_owner ? rq1_wr.data : rq0_wr.data) : MEMORY_WIDTH'(0);
        rq0_wr.ready = wr_state == WR_DATA && wr_owner == RQ_VALSET && mem_wr.ready;
        rq1_wr.ready = wr_state == WR_DATA && wr_owner == RQ_SCAN && mem_wr.ready;
        wr_beat = mem_wr.valid && mem_wr.ready;
        if (|wr_gnt && wr_cmd_len != '0) wr_state_n = WR_DATA;
        else if (wr_beat && wr_cnt == wr_len - 8'd1) wr_state_n = WR_IDLE;
    end

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (rst) wr_state <= WR_IDLE;
        else wr_state <= wr_state_n;
    end

    // Write lock owner, burst length and beat count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_owner <= RQ_VALSET;
            wr_len <= '0;
            wr_cnt <= '0;
        end else if (|wr_gnt) begin
            wr_owner <= wr_id;
            wr_len <= wr_cmd_len;
            wr_cnt <= '0;
        end else if (wr_beat) begin
            wr_cnt <= wr_cnt + 8'd1;
        end
    end

    // One-entry registered command stages toward memory; L=0 reads are swallowed here
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rdcmd.valid <= 1'b0;
            mem_rdcmd.data <= '0;
            mem_wrcmd.valid <= 1'b0;
            mem_wrcmd.data <= '0;
        end else begin
            if (rd_push) begin
                mem_rdcmd.valid <= 1'b1;
                mem_rdcmd.data <= rd_cmd;
            end else if (mem_rdcmd.ready) begin
                mem_rdcmd.valid <= 1'b0;
            end
            if (|wr_gnt) begin
                mem_wrcmd.valid <= 1'b1;
                mem_wrcmd.data <= wr_cmd;
            end else if (mem_wrcmd.ready) begin
                mem_wrcmd.valid <= 1'b0;
            end
        end
    end

    // Order FIFO pointers and per-burst read beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (rd_push) wp <= wp + AW'(1);
            if (rd_pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(rd_push) - (AW+1)'(rd_pop);
            if (rd_pop) rd_cnt <= '0;
            else if (rd_beat) rd_cnt <= rd_cnt + 8'd1;
        end
    end

    // Order FIFO storage: issuing requester and burst length per read
    always_ff @(posedge clk) begin
        if (rd_push) ord_mem[wp] <= {rd_id, rd_len};
    end

`ifdef MUU_MEMARB_STATS_EN
    // Saturating grant and FIFO-full counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rdcmd0 <= '0;
            stat_rdcmd1 <= '0;
            stat_wrcmd0 <= '0;
            stat_wrcmd1 <= '0;
            stat_fifo_full_cycles <= '0;
        end else begin
            if (rd_gnt[0]) stat_rdcmd0 <= sat_inc(stat_rdcmd0);
            if (rd_gnt[1]) stat_rdcmd1 <= sat_inc(stat_rdcmd1);
            if (wr_gnt[0]) stat_wrcmd0 <= sat_inc(stat_wrcmd0);
            if (wr_gnt[1]) stat_wrcmd1 <= sat_inc(stat_wrcmd1);
            if (full) stat_fifo_full_cycles <= sat_inc(stat_fifo_full_cycles);
        end
    end
`endif
endmodule

// File: tb/tb_muu_mem_arbiter.sv
// tb_muu_mem_arbiter: directed self-checking bench for the memory arbiter
module tb_muu_mem_arbiter;
    import muu_mem_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int npass = 0;
    int ntot = 0;

    muu_mem_arbiter_if #(40) rq0_rdcmd();
    muu_mem_arbiter_if #(40) rq1_rdcmd();
    muu_mem_arbiter_if #(40) rq0_wrcmd();
    muu_mem_arbiter_if #(40) rq1_wrcmd();
    muu_mem_arbiter_if #(512) rq0_wr();
    muu_mem_arbiter_if #(512) rq1_wr();
    muu_mem_arbiter_if #(512) rq0_rd();
    muu_mem_arbiter_if #(512) rq1_rd();
    muu_mem_arbiter_if #(40) mem_rdcmd();
    muu_mem_arbiter_if #(40) mem_wrcmd();
    muu_mem_arbiter_if #(512) mem_wr();
    muu_mem_arbiter_if #(512) mem_rd();
`ifdef MUU_MEMARB_STATS_EN
    logic [31:0] s_rd0, s_rd1, s_wr0, s_wr1, s_full;
`endif

    muu_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .rq0_rdcmd(rq0_rdcmd), .rq1_rdcmd(rq1_rdcmd),
        .rq0_wrcmd(rq0_wrcmd), .rq1_wrcmd(rq1_wrcmd),
        .rq0_wr(rq0_wr), .rq1_wr(rq1_wr),
        .rq0_rd(rq0_rd), .rq1_rd(rq1_rd),
        .mem_rdcmd(mem_rdcmd), .mem_wrcmd(mem_wrcmd),
        .mem_wr(mem_wr), .mem_rd(mem_rd)
`ifdef MUU_MEMARB_STATS_EN
        , .stat_rdcmd0(s_rd0), .stat_rdcmd1(s_rd1), .stat_wrcmd0(s_wr0),
        .stat_wrcmd1(s_wr1), .stat_fifo_full_cycles(s_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic c(input string t, input logic [63:0] o, input logic [63:0] e);
        ntot++;
        assert (o === e) npass++;
        else $error("FAIL %s: observed %0h expected %0h", t, o, e);
    endtask

    function automatic logic [39:0] cmd(input logic [7:0] l, input logic [31:0] a);
        return {l, a};
    endfunction

    initial begin
        rq0_rdcmd.valid = 0; rq0_rdcmd.data = '0;
        rq1_rdcmd.valid = 0; rq1_rdcmd.data = '0;
        rq0_wrcmd.valid = 0; rq0_wrcmd.data = '0;
        rq1_wrcmd.valid = 0; rq1_wrcmd.data = '0;
        rq0_wr.valid = 0; rq0_wr.data = '0;
        rq1_wr.valid = 0; rq1_wr.data = '0;
        rq0_rd.ready = 1; rq1_rd.ready = 1;
        mem_rdcmd.ready = 1; mem_wrcmd.ready = 1; mem_wr.ready = 1;
        mem_rd.valid = 0; mem_rd.data = '0;
        tick(); tick();
        c("rst_rdcmd_v", 64'(mem_rdcmd.valid), 64'd0);
        c("rst_wrcmd_v", 64'(mem_wrcmd.valid), 64'd0);
        c("rst_wr_v", 64'(mem_wr.valid), 64'd0);
        c("rst_rd_ready", 64'(mem_rd.ready), 64'd0);
        c("rst_wrcmd_data", 64'(mem_wrcmd.data), 64'd0);
        rst = 0;

        // 1: rq0 write L=3 with rq1 write L=1 pending
        rq0_wrcmd.valid = 1; rq0_wrcmd.data = cmd(8'd3, 32'h100);
        rq1_wrcmd.valid = 1; rq1_wrcmd.data = cmd(8'd1, 32'h200);
        rq0_wr.valid = 1; rq0_wr.data = 512'hA0;
        rq1_wr.valid = 1; rq1_wr.data = 512'hB0;
        #1;
        c("t1_gnt0", 64'({rq1_wrcmd.ready, rq0_wrcmd.ready}), 64'h1);
        c("t1_beat_holdoff", 64'(rq0_wr.ready), 64'd0);
        tick();
        rq0_wrcmd.valid = 0;
        #1;
        c("t1_cmd0_v", 64'(mem_wrcmd.valid), 64'd1);
        c("t1_cmd0_d", 64'(mem_wrcmd.data), 64'h03_0000_0100);
        c("t1_b0", 64'(mem_wr.data[63:0]), 64'hA0);
        c("t1_rq1_rdy_b0", 64'(rq1_wr.ready), 64'd0);
        c("t1_rq1_cmd_blk", 64'(rq1_wrcmd.ready), 64'd0);
        tick();
        rq0_wr.data = 512'hA1;
        #1;
        c("t1_b1", 64'(mem_wr.data[63:0]), 64'hA1);
        c("t1_cmd_drain", 64'(mem_wrcmd.valid), 64'd0);
        c("t1_rq1_rdy_b1", 64'(rq1_wr.ready), 64'd0);
        tick();
        rq0_wr.data = 512'hA2;
        #1;
        c("t1_b2", 64'(mem_wr.data[63:0]), 64'hA2);
        c("t1_rq1_rdy_b2", 64'(rq1_wr.ready), 64'd0);
        tick();
        rq0_wr.valid = 0;
        #1;
        c("t1_idle_wr_v", 64'(mem_wr.valid), 64'd0);
        c("t1_gnt1", 64'({rq1_wrcmd.ready, rq0_wrcmd.ready}), 64'h2);
        tick();
        rq1_wrcmd.valid = 0;
        #1;
        c("t1_cmd1_d", 64'(mem_wrcmd.data), 64'h01_0000_0200);
        c("t1_rq1_rdy", 64'(rq1_wr.ready), 64'd1);
        c("t1_b_rq1", 64'(mem_wr.data[63:0]), 64'hB0);
        tick();
        rq1_wr.valid = 0;
        #1;
        c("t1_end_wr_v", 64'(mem_wr.valid), 64'd0);

        // 2: both requesters stream L=2 reads, grants alternate
        rq0_rdcmd.valid = 1; rq0_rdcmd.data = cmd(8'd2, 32'h1000);
        rq1_rdcmd.valid = 1; rq1_rdcmd.data = cmd(8'd2, 32'h2000);
        for (int i = 0; i < 8; i++) begin
            #1;
            c("t2_gnt", 64'({rq1_rdcmd.ready, rq0_rdcmd.ready}), (i % 2 == 0) ? 64'h1 : 64'h2);
            tick();
            c("t2_cmd_v", 64'(mem_rdcmd.valid), 64'd1);
            c("t2_cmd_d", 64'(mem_rdcmd.data), (i % 2 == 0) ? 64'h02_0000_1000 : 64'h02_0000_2000);
        end
        rq0_rdcmd.valid = 0; rq1_rdcmd.valid = 0;
        tick();
        mem_rd.valid = 1;
        for (int j = 0; j < 16; j++) begin
            mem_rd.data = 512'(j + 16'h100);
            #1;
            c("t2_route", 64'({rq1_rd.valid, rq0_rd.valid}), ((j / 2) % 2 == 0) ? 64'h1 : 64'h2);
            c("t2_data", ((j / 2) % 2 == 0) ? 64'(rq0_rd.data[63:0]) : 64'(rq1_rd.data[63:0]), 64'(j + 16'h100));
            tick();
        end
        #1;
        c("t2_empty_noack", 64'(mem_rd.ready), 64'd0);
        mem_rd.valid = 0;

        // 3: order FIFO fills at 16 outstanding reads
        rq0_rdcmd.valid = 1; rq0_rdcmd.data = cmd(8'd1, 32'h3000);
        for (int i = 0; i < 16; i++) tick();
        #1;
        c("t3_full_blk", 64'(rq0_rdcmd.ready), 64'd0);
        tick();
        c("t3_full_blk2", 64'(rq0_rdcmd.ready), 64'd0);
        mem_rd.valid = 1; mem_rd.data = 512'h55;
        #1;
        c("t3_pop_rdy", 64'(mem_rd.ready), 64'd1);
        c("t3_pop_data", 64'(rq0_rd.data[63:0]), 64'h55);
        c("t3_still_full", 64'(rq0_rdcmd.ready), 64'd0);
        tick();
        mem_rd.valid = 0;
        #1;
        c("t3_accept17", 64'(rq0_rdcmd.ready), 64'd1);
        tick();
        rq0_rdcmd.valid = 0;
        mem_rd.valid = 1;
        for (int i = 0; i < 16; i++) tick();
        #1;
        c("t3_drained", 64'(mem_rd.ready), 64'd0);
        mem_rd.valid = 0;

        // 4: stalled head owner blocks later reads of the other requester
        rq0_rdcmd.valid = 1; rq0_rdcmd.data = cmd(8'd1, 32'h4000);
        tick();
        rq0_rdcmd.valid = 0;
        rq1_rdcmd.valid = 1; rq1_rdcmd.data = cmd(8'd1, 32'h5000);
        #1;
        c("t4_rq1_gnt", 64'(rq1_rdcmd.ready), 64'd1);
        tick();
        rq1_rdcmd.valid = 0;
        rq0_rd.ready = 0;
        mem_rd.valid = 1; mem_rd.data = 512'h77;
        #1;
        c("t4_stall_rdy", 64'(mem_rd.ready), 64'd0);
        c("t4_rq1_none", 64'(rq1_rd.valid), 64'd0);
        c("t4_rq0_sees", 64'(rq0_rd.valid), 64'd1);
        tick();
        c("t4_rq1_none2", 64'(rq1_rd.valid), 64'd0);
        rq0_rd.ready = 1;
        #1;
        c("t4_rdy", 64'(mem_rd.ready), 64'd1);
        c("t4_rq0_data", 64'(rq0_rd.data[63:0]), 64'h77);
        tick();
        mem_rd.data = 512'h78;
        #1;
        c("t4_rq1_route", 64'({rq1_rd.valid, rq0_rd.valid}), 64'h2);
        c("t4_rq1_data", 64'(rq1_rd.data[63:0]), 64'h78);
        tick();
        mem_rd.valid = 0;

        // 5: L=0 write forwards without locking data
        rq1_wrcmd.valid = 1; rq1_wrcmd.data = cmd(8'd0, 32'h400);
        rq1_wr.valid = 1; rq1_wr.data = 512'hBB;
        #1;
        c("t5_gnt_l0", 64'(rq1_wrcmd.ready), 64'd1);
        tick();
        rq1_wrcmd.valid = 0;
        rq0_wrcmd.valid = 1; rq0_wrcmd.data = cmd(8'd2, 32'h500);
        #1;
        c("t5_l0_fwd", 64'(mem_wrcmd.data), 64'h00_0000_0400);
        c("t5_no_lock", 64'(rq1_wr.ready), 64'd0);
        c("t5_no_wr_v", 64'(mem_wr.valid), 64'd0);
        c("t5_gnt_next", 64'(rq0_wrcmd.ready), 64'd1);
        tick();
        rq0_wrcmd.valid = 0; rq1_wr.valid = 0;
        rq0_wr.valid = 1; rq0_wr.data = 512'hC0;
        #1;
        c("t5_cmd_d", 64'(mem_wrcmd.data), 64'h02_0000_0500);
        c("t5_b0", 64'(mem_wr.data[63:0]), 64'hC0);
        tick();
        rq0_wr.data = 512'hC1;
        #1;
        c("t5_b1", 64'(mem_wr.data[63:0]), 64'hC1);
        tick();
        rq0_wr.valid = 0;

        // 6: reset in the middle of a 4-beat write burst
        rq0_wrcmd.valid = 1; rq0_wrcmd.data = cmd(8'd4, 32'h600);
        tick();
        rq0_wrcmd.valid = 0;
        rq0_wr.valid = 1; rq0_wr.data = 512'hD0;
        tick();
        rq0_wr.data = 512'hD1;
        rst = 1;
        #1;
        c("t6_beat2", 64'(mem_wr.data[63:0]), 64'hD1);
        tick();
        rst = 0;
        rq0_wr.valid = 0;
        #1;
        c("t6_wr_v", 64'(mem_wr.valid), 64'd0);
        c("t6_wrcmd_v", 64'(mem_wrcmd.valid), 64'd0);
        c("t6_state", 64'(dut.wr_state), 64'(WR_IDLE));
        rq0_wrcmd.valid = 1; rq0_wrcmd.data = cmd(8'd1, 32'h700);
        #1;
        c("t6_regnt", 64'(rq0_wrcmd.ready), 64'd1);
        tick();
        rq0_wrcmd.valid = 0;
        rq0_wr.valid = 1; rq0_wr.data = 512'hE0;
        #1;
        c("t6_cmd_d", 64'(mem_wrcmd.data), 64'h01_0000_0700);
        c("t6_beat", 64'(mem_wr.data[63:0]), 64'hE0);
        tick();
        rq0_wr.valid = 0;
        #1;
        c("t6_done_v", 64'(mem_wr.valid), 64'd0);
        c("t6_done_state", 64'(dut.wr_state), 64'(WR_IDLE));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
